// File: rtl/instr_loader.sv
// instr_loader: receives a program over a UART byte stream and writes it to
// instruction memory one 32-bit word at a time. Then it takes a mode byte
// that selects continuous or single-step execution.
// Optional feature: define LOADER_TIMEOUT_EN to abort a stalled load after
// TIMEOUT_CYCLES idle cycles in RECV.
module instr_loader #(
    parameter int NB_DATA        = 32,
    parameter int N_BITS_DATA    = 8,
    parameter int NB_ADDR        = 8,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [N_BITS_DATA-1:0] rx_data_i,
    input  logic                   rx_done_i,
    input  logic                   halt_i,
    output logic                   imem_wr_en_o,
    output logic [NB_ADDR-1:0]     imem_addr_o,
    output logic [NB_DATA-1:0]     imem_data_o,
    output logic [N_BITS_DATA-1:0] n_instr_o,
    output logic                   load_done_o,
    output logic                   run_o,
    output logic                   mode_step_o,
    output logic                   step_o,
    output logic                   err_o
);

    typedef enum logic [2:0] {
        IDLE, RECV, WRITE, WAIT_MODE, RUN_CONT, RUN_STEP, ERROR
    } state_t;

    localparam logic [N_BITS_DATA-1:0] MODE_STEP = N_BITS_DATA'(8'h0F);
    localparam logic [N_BITS_DATA-1:0] MODE_CONT = N_BITS_DATA'(8'hF0);
    localparam logic [N_BITS_DATA-1:0] CMD_STEP  = N_BITS_DATA'(8'h01);
    localparam logic [N_BITS_DATA-1:0] CMD_EXIT  = N_BITS_DATA'(8'hFF);

    state_t                 state, state_nxt;
    logic [NB_ADDR-1:0]     word_idx, word_idx_nxt;
    logic [1:0]             byte_idx, byte_idx_nxt;
    logic [NB_DATA-1:0]     asm_buf, asm_nxt, word_asm;
    logic                   wr_en_nxt, load_done_nxt, run_nxt, mode_step_nxt;
    logic                   step_nxt, err_nxt;
    logic [NB_ADDR-1:0]     addr_nxt;
    logic [NB_DATA-1:0]     data_nxt;
    logic [N_BITS_DATA-1:0] n_instr_nxt;
    logic                   last_word;

`ifdef LOADER_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TMO_W-1:0] tmo_cnt, tmo_nxt;
`else
    // The timeout limit has no effect in this build.
    logic unused_tmo;
    assign unused_tmo = ^TIMEOUT_CYCLES;
`endif

    // The word just written is the last one of the program.
    assign last_word = (32'(word_idx) + 32'd1) == 32'(n_instr_o);

    // Next-state and next-output logic. Outputs are registered, so every
    // strobe appears in the cycle after the byte that caused it.
    always_comb begin
        state_nxt     = state;
        word_idx_nxt  = word_idx;
        byte_idx_nxt  = byte_idx;
        asm_nxt       = asm_buf;
        word_asm      = asm_buf;
        wr_en_nxt     = 1'b0;
        addr_nxt      = imem_addr_o;
        data_nxt      = imem_data_o;
        n_instr_nxt   = n_instr_o;
        load_done_nxt = load_done_o;
        run_nxt       = run_o;
        mode_step_nxt = mode_step_o;
        step_nxt      = 1'b0;
        err_nxt       = err_o;
`ifdef LOADER_TIMEOUT_EN
        tmo_nxt       = '0;
`endif
        word_asm[int'(byte_idx) * N_BITS_DATA +: N_BITS_DATA] = rx_data_i;

        case (state)
            IDLE: begin
                if (rx_done_i) begin
                    n_instr_nxt = rx_data_i;
                    if (rx_data_i == '0) begin
                        state_nxt     = WAIT_MODE;
                        load_done_nxt = 1'b1;
                    end else begin
                        state_nxt    = RECV;
                        word_idx_nxt = '0;
                        byte_idx_nxt = '0;
                    end
                end
            end
            RECV: begin
                if (rx_done_i) begin
                    asm_nxt = word_asm;
                    if (byte_idx == 2'd3) begin
                        wr_en_nxt    = 1'b1;
                        addr_nxt     = word_idx;
                        data_nxt     = word_asm;
                        byte_idx_nxt = '0;
                        state_nxt    = WRITE;
                    end else begin
                        byte_idx_nxt = byte_idx + 2'd1;
                    end
                end
`ifdef LOADER_TIMEOUT_EN
                else if (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1)) begin
                    state_nxt = ERROR;
                    err_nxt   = 1'b1;
                end else begin
                    tmo_nxt = tmo_cnt + 1'b1;
                end
`endif
            end
            WRITE: begin
                if (last_word) begin
                    state_nxt     = WAIT_MODE;
                    load_done_nxt = 1'b1;
                end else begin
                    state_nxt    = RECV;
                    word_idx_nxt = word_idx + 1'b1;
                    // A byte landing in the write cycle starts the next word.
                    if (rx_done_i) begin
                        asm_nxt      = word_asm;
                        byte_idx_nxt = 2'd1;
                    end
                end
            end
            WAIT_MODE: begin
                if (rx_done_i) begin
                    if (rx_data_i == MODE_STEP) begin
                        state_nxt     = RUN_STEP;
                        mode_step_nxt = 1'b1;
                    end else if (rx_data_i == MODE_CONT) begin
                        state_nxt = RUN_CONT;
                        run_nxt   = 1'b1;
                    end else begin
                        state_nxt = ERROR;
                        err_nxt   = 1'b1;
                    end
                end
            end
            RUN_STEP: begin
                if (rx_done_i && rx_data_i == CMD_STEP) step_nxt  = 1'b1;
                if (rx_done_i && rx_data_i == CMD_EXIT) state_nxt = IDLE;
            end
            RUN_CONT: begin
                if (halt_i || (rx_done_i && rx_data_i == CMD_EXIT)) state_nxt = IDLE;
            end
            ERROR:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase

        // Status levels drop together with the return to IDLE.
        if (state_nxt == IDLE) begin
            load_done_nxt = 1'b0;
            run_nxt       = 1'b0;
            mode_step_nxt = 1'b0;
        end
    end

    // State, indices and outputs; cleared asynchronously by reset.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            word_idx     <= '0;
            byte_idx     <= '0;
            imem_wr_en_o <= 1'b0;
            imem_addr_o  <= '0;
            imem_data_o  <= '0;
            n_instr_o    <= '0;
            load_done_o  <= 1'b0;
            run_o        <= 1'b0;
            mode_step_o  <= 1'b0;
            step_o       <= 1'b0;
            err_o        <= 1'b0;
`ifdef LOADER_TIMEOUT_EN
            tmo_cnt      <= '0;
`endif
        end else begin
            state        <= state_nxt;
            word_idx     <= word_idx_nxt;
            byte_idx     <= byte_idx_nxt;
            imem_wr_en_o <= wr_en_nxt;
            imem_addr_o  <= addr_nxt;
            imem_data_o  <= data_nxt;
            n_instr_o    <= n_instr_nxt;
            load_done_o  <= load_done_nxt;
            run_o        <= run_nxt;
            mode_step_o  <= mode_step_nxt;
            step_o       <= step_nxt;
            err_o        <= err_nxt;
`ifdef LOADER_TIMEOUT_EN
            tmo_cnt      <= tmo_nxt;
`endif
        end
    end

    // Word assembly buffer; partial contents are overwritten byte by byte.
    always_ff @(posedge clock) begin
        asm_buf <= asm_nxt;
    end

endmodule
